// File: rtl/ptp_bridge_igr_pkt_mux.sv
// rtl/ptp_bridge_igr_pkt_mux.sv - ingress packet mux forwarding one granted port's packet at a time
module ptp_bridge_igr_pkt_mux #(
  parameter int N       = 2,
  parameter int DW      = 64,
  parameter int EW      = 3,
  parameter int N_WIDTH = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_WIDTH-1:0]     gnt,
  input  logic                   gnt_vld,
  output logic                   gnt_in_flight,
  output logic                   gnt_pop,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  input  logic [N-1:0][DW-1:0]   in_data,
  input  logic [N-1:0]           in_sop,
  input  logic [N-1:0]           in_eop,
  input  logic [N-1:0][EW-1:0]   in_empty,
  output logic                   out_valid,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic [DW-1:0]          out_data,
  output logic [EW-1:0]          out_empty,
  output logic [N_WIDTH-1:0]     out_port,
  input  logic                   out_ready,
  output logic [N-1:0][31:0]     pkt_cnt,
  output logic [N-1:0]           sop_err
);

  typedef enum logic [1:0] {IDLE, XFER, POP} state_t;

  state_t             state, state_next;
  logic [N_WIDTH-1:0] cur_port;
  logic               first_beat;
  logic               grant_take;
  logic               accept;
  logic               acc_sop, acc_eop;

  always_comb begin
    in_ready = '0;
    if (state == XFER && (!out_valid || out_ready))
      in_ready[cur_port] = 1'b1;
  end

  assign accept  = in_ready[cur_port] & in_valid[cur_port];
  assign acc_sop = in_sop[cur_port];
  assign acc_eop = in_eop[cur_port];

  always_comb begin
    state_next = state;
    grant_take = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld && !gnt_pop) begin
          state_next = XFER;
          grant_take = 1'b1;
        end
      end
      XFER:    if (accept && acc_eop) state_next = POP;
      POP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_port      <= '0;
      first_beat    <= 1'b0;
      gnt_in_flight <= 1'b0;
      gnt_pop       <= 1'b0;
      out_valid     <= 1'b0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_data      <= '0;
      out_empty     <= '0;
      out_port      <= '0;
      pkt_cnt       <= '0;
      sop_err       <= '0;
    end else begin
      state         <= state_next;
      gnt_in_flight <= (state_next != IDLE);
      gnt_pop       <= (state_next == POP);
      if (grant_take) begin
        cur_port   <= gnt;
        first_beat <= 1'b1;
      end
      if (accept) begin
        first_beat <= 1'b0;
        out_valid  <= 1'b1;
        out_sop    <= acc_sop;
        out_eop    <= acc_eop;
        out_data   <= in_data[cur_port];
        out_empty  <= acc_eop ? in_empty[cur_port] : '0;
        out_port   <= cur_port;
        // A missing sop on the first beat or a stray sop mid-packet is flagged but still forwarded
        if (first_beat != acc_sop)
          sop_err[cur_port] <= 1'b1;
        if (acc_eop && pkt_cnt[cur_port] != 32'hFFFF_FFFF)
          pkt_cnt[cur_port] <= pkt_cnt[cur_port] + 32'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ptp_bridge_igr_pkt_mux.sv
// tb/tb_ptp_bridge_igr_pkt_mux.sv - directed self-checking bench for ptp_bridge_igr_pkt_mux
module tb_ptp_bridge_igr_pkt_mux;
  localparam int N = 4, DW = 16, EW = 3, NW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NW-1:0]        gnt;
  logic                 gnt_vld;
  logic                 gnt_in_flight, gnt_pop;
  logic [N-1:0]         in_valid, in_ready, in_sop, in_eop;
  logic [N-1:0][DW-1:0] in_data;
  logic [N-1:0][EW-1:0] in_empty;
  logic                 out_valid, out_sop, out_eop, out_ready;
  logic [DW-1:0]        out_data;
  logic [EW-1:0]        out_empty;
  logic [NW-1:0]        out_port;
  logic [N-1:0][31:0]   pkt_cnt;
  logic [N-1:0]         sop_err;

  int checks = 0;
  int failures = 0;

  ptp_bridge_igr_pkt_mux #(.N(N), .DW(DW), .EW(EW), .N_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .gnt(gnt), .gnt_vld(gnt_vld),
    .gnt_in_flight(gnt_in_flight), .gnt_pop(gnt_pop),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_data(out_data), .out_empty(out_empty), .out_port(out_port),
    .out_ready(out_ready), .pkt_cnt(pkt_cnt), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks += 8;
    if (gnt_in_flight !== 1'b0) begin failures++; $display("FAIL reset_in_flight got %0h want 0", gnt_in_flight); end
    if (gnt_pop !== 1'b0) begin failures++; $display("FAIL reset_pop got %0h want 0", gnt_pop); end
    if (in_ready !== 4'b0) begin failures++; $display("FAIL reset_in_ready got %0h want 0", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    if (out_port !== 2'd0) begin failures++; $display("FAIL reset_out_port got %0h want 0", out_port); end
    if (pkt_cnt !== '0) begin failures++; $display("FAIL reset_pkt_cnt got %0h want 0", pkt_cnt); end
    if (sop_err !== 4'b0) begin failures++; $display("FAIL reset_sop_err got %0h want 0", sop_err); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    gnt = 2'd2; gnt_vld = 1'b1;
    tick;
    checks += 2;
    if (gnt_in_flight !== 1'b1) begin failures++; $display("FAIL basic_in_flight got %0h want 1", gnt_in_flight); end
    if (gnt_pop !== 1'b0) begin failures++; $display("FAIL basic_pop_early got %0h want 0", gnt_pop); end
    gnt_vld = 1'b0;
    in_valid[2] = 1'b1; in_sop[2] = 1'b1; in_eop[2] = 1'b0; in_data[2] = 16'hA000;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin failures++; $display("FAIL basic_in_ready got %0h want 4", in_ready); end
    tick;
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_b0_valid got %0h want 1", out_valid); end
    if (out_data !== 16'hA000 || out_sop !== 1'b1) begin failures++; $display("FAIL basic_b0 got data=%0h sop=%0h want A000/1", out_data, out_sop); end
    if (out_port !== 2'd2) begin failures++; $display("FAIL basic_b0_port got %0h want 2", out_port); end
    in_sop[2] = 1'b0; in_data[2] = 16'hA001; in_empty[2] = 3'd3;
    tick;
    checks += 2;
    if (out_data !== 16'hA001 || out_sop !== 1'b0 || out_port !== 2'd2) begin failures++; $display("FAIL basic_b1 got data=%0h sop=%0h port=%0h want A001/0/2", out_data, out_sop, out_port); end
    if (out_empty !== 3'd0) begin failures++; $display("FAIL basic_b1_empty got %0h want 0", out_empty); end
    in_eop[2] = 1'b1; in_empty[2] = 3'd5; in_data[2] = 16'hA002;
    tick;
    checks += 4;
    if (out_data !== 16'hA002 || out_eop !== 1'b1 || out_port !== 2'd2) begin failures++; $display("FAIL basic_b2 got data=%0h eop=%0h port=%0h want A002/1/2", out_data, out_eop, out_port); end
    if (out_empty !== 3'd5) begin failures++; $display("FAIL basic_b2_empty got %0h want 5", out_empty); end
    if (gnt_pop !== 1'b1 || gnt_in_flight !== 1'b1) begin failures++; $display("FAIL basic_pop got pop=%0h flight=%0h want 1/1", gnt_pop, gnt_in_flight); end
    if (pkt_cnt[2] !== 32'd1) begin failures++; $display("FAIL basic_pkt_cnt got %0h want 1", pkt_cnt[2]); end
    in_valid[2] = 1'b0; in_eop[2] = 1'b0; in_empty[2] = 3'd0;
    tick;
    checks++;
    if (gnt_pop !== 1'b0 || gnt_in_flight !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_idle got pop=%0h flight=%0h valid=%0h want 0/0/0", gnt_pop, gnt_in_flight, out_valid); end
  endtask

  task automatic test_stall;
    gnt = 2'd0; gnt_vld = 1'b1;
    tick;
    gnt_vld = 1'b0;
    in_valid[0] = 1'b1; in_sop[0] = 1'b1; in_data[0] = 16'h0010;
    tick;
    checks++;
    if (out_data !== 16'h0010) begin failures++; $display("FAIL stall_b0 got %0h want 10", out_data); end
    out_ready = 1'b0; in_sop[0] = 1'b0; in_data[0] = 16'h0011;
    #1;
    checks++;
    if (in_ready !== 4'b0) begin failures++; $display("FAIL stall_ready got %0h want 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0010 || out_sop !== 1'b1 || in_ready !== 4'b0)
        begin failures++; $display("FAIL stall_hold%0d got valid=%0h data=%0h sop=%0h rdy=%0h want 1/10/1/0", i, out_valid, out_data, out_sop, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL stall_release got %0h want 1", in_ready); end
    tick;
    checks++;
    if (out_data !== 16'h0011 || out_sop !== 1'b0) begin failures++; $display("FAIL stall_b1 got data=%0h sop=%0h want 11/0", out_data, out_sop); end
    in_eop[0] = 1'b1; in_data[0] = 16'h0012;
    tick;
    checks++;
    if (out_data !== 16'h0012 || gnt_pop !== 1'b1) begin failures++; $display("FAIL stall_b2 got data=%0h pop=%0h want 12/1", out_data, gnt_pop); end
    in_valid[0] = 1'b0; in_eop[0] = 1'b0;
    tick;
    checks++;
    if (pkt_cnt[0] !== 32'd1) begin failures++; $display("FAIL stall_pkt_cnt got %0h want 1", pkt_cnt[0]); end
  endtask

  task automatic test_isolation;
    gnt = 2'd0; gnt_vld = 1'b1;
    in_valid[1] = 1'b1; in_sop[1] = 1'b1; in_data[1] = 16'hBAD0;
    tick;
    checks++;
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL iso_ready0 got %0h want 1", in_ready); end
    gnt = 2'd1;
    in_valid[0] = 1'b1; in_sop[0] = 1'b1; in_data[0] = 16'h0020;
    tick;
    checks += 2;
    if (out_port !== 2'd0 || out_data !== 16'h0020) begin failures++; $display("FAIL iso_b0 got port=%0h data=%0h want 0/20", out_port, out_data); end
    if (in_ready !== 4'b0001) begin failures++; $display("FAIL iso_ready1 got %0h want 1", in_ready); end
    in_sop[0] = 1'b0; in_eop[0] = 1'b1; in_data[0] = 16'h0021;
    tick;
    checks++;
    if (out_port !== 2'd0 || out_data !== 16'h0021 || gnt_pop !== 1'b1) begin failures++; $display("FAIL iso_b1 got port=%0h data=%0h pop=%0h want 0/21/1", out_port, out_data, gnt_pop); end
    gnt_vld = 1'b0; in_valid[0] = 1'b0; in_eop[0] = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0) begin failures++; $display("FAIL iso_ready_pop got %0h want 0", in_ready); end
    tick;
    in_valid[1] = 1'b0; in_sop[1] = 1'b0;
    checks++;
    if (pkt_cnt[1] !== 32'd0 || pkt_cnt[0] !== 32'd2) begin failures++; $display("FAIL iso_cnt got p0=%0h p1=%0h want 2/0", pkt_cnt[0], pkt_cnt[1]); end
  endtask

  task automatic test_back_to_back;
    gnt = 2'd3; gnt_vld = 1'b1;
    in_valid[3] = 1'b1; in_sop[3] = 1'b1; in_eop[3] = 1'b1; in_data[3] = 16'h0030;
    for (int k = 1; k <= 12; k++) begin
      tick;
      checks++;
      if (gnt_pop !== ((k % 3) == 2)) begin failures++; $display("FAIL b2b_pop k=%0d got %0h want %0h", k, gnt_pop, (k % 3) == 2); end
      if ((k % 3) == 2) begin
        checks++;
        if (out_port !== 2'd3 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out k=%0d got port=%0h valid=%0h want 3/1", k, out_port, out_valid); end
      end
      if (k == 12) gnt_vld = 1'b0;
    end
    in_valid[3] = 1'b0; in_sop[3] = 1'b0; in_eop[3] = 1'b0;
    tick;
    checks++;
    if (pkt_cnt[3] !== 32'd4) begin failures++; $display("FAIL b2b_pkt_cnt got %0h want 4", pkt_cnt[3]); end
  endtask

  task automatic test_sop_err;
    gnt = 2'd1; gnt_vld = 1'b1;
    tick;
    gnt_vld = 1'b0;
    in_valid[1] = 1'b1; in_sop[1] = 1'b0; in_data[1] = 16'h0041;
    tick;
    checks += 2;
    if (out_data !== 16'h0041 || out_sop !== 1'b0) begin failures++; $display("FAIL serr_fwd got data=%0h sop=%0h want 41/0", out_data, out_sop); end
    if (sop_err !== 4'b0010) begin failures++; $display("FAIL serr_first got %0h want 2", sop_err); end
    in_eop[1] = 1'b1; in_data[1] = 16'h0042;
    tick;
    checks++;
    if (gnt_pop !== 1'b1) begin failures++; $display("FAIL serr_pop got %0h want 1", gnt_pop); end
    in_valid[1] = 1'b0; in_eop[1] = 1'b0;
    tick;
    gnt = 2'd2; gnt_vld = 1'b1;
    tick;
    gnt_vld = 1'b0;
    checks++;
    if (sop_err !== 4'b0010) begin failures++; $display("FAIL serr_sticky got %0h want 2", sop_err); end
    in_valid[2] = 1'b1; in_sop[2] = 1'b1; in_data[2] = 16'h0050;
    tick;
    checks++;
    if (sop_err !== 4'b0010) begin failures++; $display("FAIL serr_good_sop got %0h want 2", sop_err); end
    in_eop[2] = 1'b1; in_data[2] = 16'h0051;
    tick;
    checks++;
    if (sop_err !== 4'b0110 || out_sop !== 1'b1 || out_data !== 16'h0051) begin failures++; $display("FAIL serr_mid got err=%0h sop=%0h data=%0h want 6/1/51", sop_err, out_sop, out_data); end
    in_valid[2] = 1'b0; in_sop[2] = 1'b0; in_eop[2] = 1'b0;
    tick;
    checks++;
    if (sop_err !== 4'b0110) begin failures++; $display("FAIL serr_hold got %0h want 6", sop_err); end
  endtask

  task automatic test_reset_mid;
    gnt = 2'd2; gnt_vld = 1'b1;
    tick;
    gnt_vld = 1'b0;
    in_valid[2] = 1'b1; in_sop[2] = 1'b1; in_data[2] = 16'h0060;
    tick;
    in_sop[2] = 1'b0; in_data[2] = 16'h0061;
    tick;
    in_data[2] = 16'h0062; rst = 1'b1;
    tick;
    checks += 5;
    if (gnt_in_flight !== 1'b0 || gnt_pop !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got flight=%0h pop=%0h want 0/0", gnt_in_flight, gnt_pop); end
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_port !== 2'd0 || out_sop !== 1'b0) begin failures++; $display("FAIL rmid_out got valid=%0h data=%0h port=%0h sop=%0h want 0", out_valid, out_data, out_port, out_sop); end
    if (in_ready !== 4'b0) begin failures++; $display("FAIL rmid_ready got %0h want 0", in_ready); end
    if (pkt_cnt !== '0) begin failures++; $display("FAIL rmid_cnt got %0h want 0", pkt_cnt); end
    if (sop_err !== 4'b0) begin failures++; $display("FAIL rmid_err got %0h want 0", sop_err); end
    rst = 1'b0; in_valid[2] = 1'b0;
    gnt = 2'd1; gnt_vld = 1'b1;
    tick;
    checks++;
    if (gnt_in_flight !== 1'b1 || gnt_pop !== 1'b0) begin failures++; $display("FAIL rmid_regrant got flight=%0h pop=%0h want 1/0", gnt_in_flight, gnt_pop); end
    gnt_vld = 1'b0;
    in_valid[1] = 1'b1; in_sop[1] = 1'b1; in_eop[1] = 1'b1; in_data[1] = 16'h0070;
    tick;
    checks++;
    if (out_port !== 2'd1 || out_data !== 16'h0070 || gnt_pop !== 1'b1 || pkt_cnt[1] !== 32'd1)
      begin failures++; $display("FAIL rmid_new got port=%0h data=%0h pop=%0h cnt=%0h want 1/70/1/1", out_port, out_data, gnt_pop, pkt_cnt[1]); end
    in_valid[1] = 1'b0; in_sop[1] = 1'b0; in_eop[1] = 1'b0;
    tick;
    checks++;
    if (gnt_in_flight !== 1'b0) begin failures++; $display("FAIL rmid_done got %0h want 0", gnt_in_flight); end
  endtask

  initial begin
    rst = 1'b1; gnt = '0; gnt_vld = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    test_reset;
    test_basic;
    test_stall;
    test_isolation;
    test_back_to_back;
    test_sop_err;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
